instr_fetch: RTL and testbench

//  Fetch stage directly upstream of the decode/ID stage. Owns the fetch PC and issues
//  in-order word reads to instruction memory with up to 2 requests in flight. Buffers

---
 rtl/instr_fetch_if.sv | 32 +++
 rtl/instr_fetch.sv | 146 ++++++++++++++
 tb/tb_instr_fetch.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_if.sv
// Bundle of signals between the fetch stage, instruction memory, the branch
// resolution logic and the decode stage. The fetch stage uses the master
// modport; the environment (memory, redirect source, ID) uses the slave modport.
//
// Handshake rules:
//  - imem_req has no ready: memory takes every request. Responses come back
//    in request order, at least one cycle later, flagged by imem_rvalid.
//  - out_valid/id_ready is a strict valid/ready pair. The head entry moves to
//    ID in a cycle where both are high. out_valid never depends on id_ready.
//    out_valid is forced low in any cycle where redirect_valid is high.
interface instr_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        id_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;

  modport master (
    output imem_req, imem_addr, out_valid, out_instr, out_pc,
    input  imem_rvalid, imem_rdata, redirect_valid, redirect_pc, id_ready
  );

  modport slave (
    input  imem_req, imem_addr, out_valid, out_instr, out_pc,
    output imem_rvalid, imem_rdata, redirect_valid, redirect_pc, id_ready
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage. Owns the fetch PC, keeps up to two word reads in
// flight to instruction memory and buffers the returned words, each tagged
// with its PC, in a DEPTH-entry FIFO that feeds ID. A redirect flushes the
// FIFO. Responses still owed by memory at that point are counted in r_discard
// and are dropped when they arrive.
//
// Credit rule: a request is issued only if the FIFO has room for every live
// outstanding request (count + inflight < DEPTH). So a live response always
// finds a free slot, and the FIFO never overflows.
module instr_fetch #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic          clk,
  input  logic          reset,
  instr_fetch_if.master bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = AW + 2;

  // Fetch PC and outstanding-request bookkeeping
  logic [31:0]   r_pc;
  logic [1:0]    r_inflight;
  logic [1:0]    r_discard;
  logic [31:0]   r_if_pc [2];
  logic          r_if_wptr;
  logic          r_if_rptr;

  // Instruction queue
  logic [CW-1:0] r_count;
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [31:0]   r_q_instr [DEPTH];
  logic [31:0]   r_q_pc    [DEPTH];

  // Combinational control
  logic          w_redirect;
  logic [2:0]    w_outstanding;
  logic [SW-1:0] w_credit;
  logic          w_issue;
  logic          w_resp_live;
  logic          w_resp_drop;
  logic          w_out_valid;
  logic          w_pop;
  logic [2:0]    w_discard_redir;
  logic [31:0]   w_redirect_pc;

  assign w_redirect    = bus.redirect_valid;
  assign w_redirect_pc = {bus.redirect_pc[31:2], 2'b00};
  assign w_outstanding = {1'b0, r_inflight} + {1'b0, r_discard};
  assign w_credit      = SW'(r_count) + SW'(r_inflight);

  // Issuing is gated by reset so imem_req drops immediately when reset asserts.
  assign w_issue = reset && !w_redirect && (w_outstanding < 3'd2) &&
                   (w_credit < SW'(DEPTH));

  // A response that coincides with a redirect is always dropped. Otherwise it
  // is dropped only when it belongs to an older, flushed request stream.
  assign w_resp_live = bus.imem_rvalid && !w_redirect && (r_discard == 2'd0);
  assign w_resp_drop = bus.imem_rvalid && !w_redirect && (r_discard != 2'd0);

  assign w_out_valid = (r_count != '0) && !w_redirect;
  assign w_pop       = w_out_valid && bus.id_ready;

  assign bus.imem_req  = w_issue;
  assign bus.imem_addr = r_pc;
  assign bus.out_valid = w_out_valid;
  assign bus.out_instr = r_q_instr[r_rptr];
  assign bus.out_pc    = r_q_pc[r_rptr];

  // Stale-response count after a redirect: all requests still owed by memory,
  // minus one if a response is arriving in the redirect cycle itself.
  always_comb begin
    w_discard_redir = w_outstanding;
    if (bus.imem_rvalid && (w_outstanding != 3'd0)) begin
      w_discard_redir = w_outstanding - 3'd1;
    end
  end

  // Fetch PC, in-flight PC FIFO, outstanding counters and queue pointers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc       <= RESET_PC;
      r_inflight <= 2'd0;
      r_discard  <= 2'd0;
      r_if_pc[0] <= 32'h0;
      r_if_pc[1] <= 32'h0;
      r_if_wptr  <= 1'b0;
      r_if_rptr  <= 1'b0;
      r_count    <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
    end else if (w_redirect) begin
      r_pc       <= w_redirect_pc;
      r_inflight <= 2'd0;
      r_discard  <= w_discard_redir[1:0];
      r_if_wptr  <= 1'b0;
      r_if_rptr  <= 1'b0;
      r_count    <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
    end else begin
      if (w_issue) begin
        r_pc               <= r_pc + 32'd4;
        r_if_pc[r_if_wptr] <= r_pc;
        r_if_wptr          <= ~r_if_wptr;
      end
      if (w_resp_live) begin
        r_if_rptr <= ~r_if_rptr;
        r_wptr    <= r_wptr + AW'(1);
      end
      if (w_resp_drop) begin
        r_discard <= r_discard - 2'd1;
      end
      case ({w_issue, w_resp_live})
        2'b10:   r_inflight <= r_inflight + 2'd1;
        2'b01:   r_inflight <= r_inflight - 2'd1;
        default: r_inflight <= r_inflight;
      endcase
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      case ({w_resp_live, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Queue storage: write the returned word with the PC it was fetched from
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_q_instr[i] <= 32'h0;
        r_q_pc[i]    <= 32'h0;
      end
    end else if (w_resp_live) begin
      r_q_instr[r_wptr] <= bus.imem_rdata;
      r_q_pc[r_wptr]    <= r_if_pc[r_if_rptr];
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch. A queue-based reference model of the
// fetch stage predicts the outputs every cycle. Directed scenarios pin the
// model and the design to literal values. Randomized segments then exercise
// latency, back-pressure, redirects and resets.
module tb_instr_fetch;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  typedef struct {
    int          due;
    logic [31:0] addr;
  } pend_t;

  // Clock/reset
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  instr_fetch_if bus();

  instr_fetch #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  // Reference model state
  logic [31:0] m_pc;
  logic [63:0] m_q [$];
  logic [31:0] m_if [$];
  int          m_discard;

  // Memory model and bookkeeping
  pend_t       pend [$];
  int          lat = 1;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  // Outputs observed in the most recent step
  logic        o_req, o_valid;
  logic [31:0] o_addr, o_pc, o_instr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5A5A5A5;
  endfunction

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_pc = RESET_PC;
    m_q.delete();
    m_if.delete();
    m_discard = 0;
  endtask

  // One clock cycle: compare the outputs against the model at the falling
  // edge, advance the model and the memory at the rising edge, then drive the
  // memory response for the next cycle.
  task automatic step();
    logic        e_req, e_valid, s_rv, s_redir, s_idr, s_rst;
    logic [31:0] e_addr, s_rd, s_rpc, tmp;
    int          n;
    pend_t       p;
    @(negedge clk);
    if (!rst_n) model_reset();
    e_req   = rst_n && !bus.redirect_valid && (m_if.size() + m_discard < 2) &&
              (m_q.size() + m_if.size() < DEPTH);
    e_valid = (m_q.size() != 0) && !bus.redirect_valid;
    e_addr  = m_pc;
    chk1("imem_req", bus.imem_req, e_req);
    chk32("imem_addr", bus.imem_addr, e_addr);
    chk1("out_valid", bus.out_valid, e_valid);
    if (e_valid) begin
      chk32("out_pc", bus.out_pc, m_q[0][63:32]);
      chk32("out_instr", bus.out_instr, m_q[0][31:0]);
    end else if (!rst_n) begin
      chk32("rst_out_pc", bus.out_pc, 32'h0);
      chk32("rst_out_instr", bus.out_instr, 32'h0);
    end
    o_req = bus.imem_req; o_addr = bus.imem_addr; o_valid = bus.out_valid;
    o_pc  = bus.out_pc;   o_instr = bus.out_instr;
    s_rv = bus.imem_rvalid; s_rd = bus.imem_rdata; s_redir = bus.redirect_valid;
    s_rpc = bus.redirect_pc; s_idr = bus.id_ready; s_rst = rst_n;
    @(posedge clk);
    if (!s_rst) begin
      model_reset();
    end else if (s_redir) begin
      n = m_discard + m_if.size() - (s_rv ? 1 : 0);
      m_discard = (n < 0) ? 0 : n;
      m_if.delete();
      m_q.delete();
      m_pc = {s_rpc[31:2], 2'b00};
    end else begin
      if (e_valid && s_idr) void'(m_q.pop_front());
      if (s_rv) begin
        if (m_discard > 0) m_discard--;
        else if (m_if.size() > 0) begin
          tmp = m_if.pop_front();
          m_q.push_back({tmp, s_rd});
        end
      end
      if (e_req) begin
        m_if.push_back(m_pc);
        m_pc = m_pc + 32'd4;
      end
    end
    if (!s_rst) pend.delete();
    else if (o_req) begin
      p.due = cyc + 1 + (lat - 1);
      p.addr = o_addr;
      pend.push_back(p);
    end
    cyc++;
    #1;
    bus.redirect_valid = 1'b0;
    bus.imem_rvalid    = 1'b0;
    if (rst_n && pend.size() > 0 && pend[0].due == cyc) begin
      p = pend.pop_front();
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = mem_word(p.addr);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic redirect(input logic [31:0] pc);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = pc;
  endtask

  // Steps until out_valid is seen (bounded), then checks the head PC and word.
  task automatic wait_valid(input string name, input logic [31:0] exp_pc);
    logic got;
    got = 1'b0;
    for (int i = 0; i < 30 && !got; i++) begin
      step();
      got = o_valid;
    end
    chk1({name, "_seen"}, got, 1'b1);
    if (got) begin
      chk32(name, o_pc, exp_pc);
      chk32({name, "_instr"}, o_instr, mem_word(exp_pc));
    end
  endtask

  initial begin
    bus.imem_rvalid = 1'b0; bus.imem_rdata = 32'h0;
    bus.redirect_valid = 1'b0; bus.redirect_pc = 32'h0;
    bus.id_ready = 1'b1;
    model_reset();

    // Reset values
    step();
    step();
    chk1("rst_req", o_req, 1'b0);
    chk32("rst_addr", o_addr, RESET_PC);
    chk1("rst_valid", o_valid, 1'b0);
    chk32("rst_pc", o_pc, 32'h0);
    chk32("rst_instr", o_instr, 32'h0);
    rst_n = 1'b1;

    // 1: streaming with latency-1 memory
    step(); chk1("t1_c0_valid", o_valid, 1'b0); chk1("t1_c0_req", o_req, 1'b1);
    step(); chk1("t1_c1_valid", o_valid, 1'b0);
    step(); chk1("t1_c2_valid", o_valid, 1'b1); chk32("t1_c2_pc", o_pc, 32'h0);
    chk32("t1_c2_instr", o_instr, 32'hA5A5A5A5);
    step(); chk32("t1_c3_pc", o_pc, 32'h4);
    step(); chk32("t1_c4_pc", o_pc, 32'h8);
    step(); chk32("t1_c5_pc", o_pc, 32'hC);
    chk32("t1_c5_instr", o_instr, 32'hA5A5A5A9);

    // 2: back-pressure fills the queue
    bus.id_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 10; i++) step();
    chk1("t2_req_stall", o_req, 1'b0);
    chk32("t2_addr_stall", o_addr, 32'h10);
    chk32("t2_head", o_pc, 32'h0);
    bus.id_ready = 1'b1;
    step(); chk32("t2_pc0", o_pc, 32'h0);
    step(); chk32("t2_pc1", o_pc, 32'h4);
    chk1("t2_resume_req", o_req, 1'b1); chk32("t2_resume_addr", o_addr, 32'h10);
    step(); chk32("t2_pc2", o_pc, 32'h8);
    step(); chk32("t2_pc3", o_pc, 32'hC);
    step(); chk32("t2_pc4", o_pc, 32'h10);

    // 3: latency-3 memory, redirect with two requests in flight
    lat = 3;
    do_reset();
    redirect(32'h20);
    step();
    step(); chk32("t3_addr20", o_addr, 32'h20); chk1("t3_req20", o_req, 1'b1);
    step(); chk32("t3_addr24", o_addr, 32'h24); chk1("t3_req24", o_req, 1'b1);
    redirect(32'h100);
    step();
    wait_valid("t3_pc", 32'h100);

    // 4: redirect coinciding with a response and id_ready
    lat = 1;
    do_reset();
    for (int i = 0; i < 6; i++) step();
    redirect(32'h200);
    step(); chk1("t4_valid_redir", o_valid, 1'b0);
    step(); chk1("t4_valid_after", o_valid, 1'b0);
    chk1("t4_req_after", o_req, 1'b1); chk32("t4_addr_after", o_addr, 32'h200);
    wait_valid("t4_pc", 32'h200);

    // 5: unaligned redirect target and PC wrap
    redirect(32'h103);
    step();
    step(); chk32("t5_addr_align", o_addr, 32'h100);
    wait_valid("t5_pc", 32'h100);
    redirect(32'hFFFFFFFC);
    step();
    step(); chk32("t5_addr_top", o_addr, 32'hFFFFFFFC); chk1("t5_req_top", o_req, 1'b1);
    step(); chk32("t5_addr_wrap", o_addr, 32'h0);
    step(); chk32("t5_pc_top", o_pc, 32'hFFFFFFFC);
    step(); chk32("t5_pc_wrap", o_pc, 32'h0);

    // 6: reset mid-stream with three queued entries
    bus.id_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 4; i++) step();
    rst_n = 1'b0;
    step(); chk1("t6_valid_async", o_valid, 1'b0); chk1("t6_req_async", o_req, 1'b0);
    rst_n = 1'b1;
    bus.id_ready = 1'b1;
    step(); chk1("t6_req_restart", o_req, 1'b1); chk32("t6_addr_restart", o_addr, RESET_PC);
    wait_valid("t6_pc", RESET_PC);

    // Randomized segments
    for (int seg = 0; seg < 8; seg++) begin
      lat = $urandom_range(1, 4);
      do_reset();
      for (int i = 0; i < 300; i++) begin
        bus.id_ready = ($urandom_range(0, 9) < 7);
        if ($urandom_range(0, 99) < 6) begin
          if ($urandom_range(0, 3) == 0) redirect(32'hFFFFFFF0 + 32'($urandom_range(0, 15)));
          else redirect($urandom);
        end
        rst_n = ($urandom_range(0, 199) != 0);
        step();
      end
      rst_n = 1'b1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
